// File: rtl/puf_soc_scan_mux.sv
// puf_soc_scan_mux
//   N_CH-to-1 PUF response selector with a registered output and an auto-scan mode.
//   It sits between the PUF cell array outputs and the response collector.
//   Manual mode registers channel[i_sel_mux] every cycle.
//   Scan mode streams channels lo..hi, one beat per channel, over o_valid/i_ready.
//
// Ports
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_data        packed responses; channel k = i_data[k*N_BIT +: N_BIT]
//   i_mode        0 = manual, 1 = scan (sampled only while idle)
//   i_sel_mux     manual-mode channel select
//   i_start       scan start pulse (idle and i_mode=1 only)
//   i_ch_lo/hi    first/last scan channel, inclusive, latched at start
//   i_abort       synchronous scan abort
//   i_ready       downstream ready
//   o_data, o_ch  registered response and its channel index
//   o_valid       scan beat valid
//   o_busy        high while not idle
//   o_done        one-cycle pulse after the last beat is accepted
//   o_err         one-cycle pulse on a rejected start

module puf_soc_scan_mux #(
    parameter int unsigned N_BIT = 1,
    parameter int unsigned N_CH  = 16,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_CH*N_BIT-1:0] i_data,
    input  logic                  i_mode,
    input  logic [SEL_W-1:0]      i_sel_mux,
    input  logic                  i_start,
    input  logic [SEL_W-1:0]      i_ch_lo,
    input  logic [SEL_W-1:0]      i_ch_hi,
    input  logic                  i_abort,
    input  logic                  i_ready,
    output logic [N_BIT-1:0]      o_data,
    output logic [SEL_W-1:0]      o_ch,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [N_BIT-1:0] data_q, data_d;
    // ch_q doubles as the scan counter: in scan mode it is always the channel on o_data.
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] hi_q, hi_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             start_ok;
    logic [SEL_W-1:0] ch_next;

    // Channel picker; selects beyond N_CH-1 (non power-of-two N_CH) return zero.
    function automatic logic [N_BIT-1:0] pick(input logic [N_CH*N_BIT-1:0] d,
                                              input logic [SEL_W-1:0] sel);
        logic [N_BIT-1:0] res;
        res = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                res = d[k*N_BIT +: N_BIT];
            end
        end
        return res;
    endfunction

    // hi <= N_CH-1 is guaranteed here, so the counter can never wrap during a scan.
    assign start_ok = (i_ch_lo <= i_ch_hi) && (32'(i_ch_hi) < N_CH);
    assign ch_next  = ch_q + SEL_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            ch_q    <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        hi_d    = hi_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!i_mode) begin
                    data_d = pick(i_data, i_sel_mux);
                    ch_d   = i_sel_mux;
                end else if (i_start) begin
                    if (start_ok) begin
                        state_d = StScan;
                        data_d  = pick(i_data, i_ch_lo);
                        ch_d    = i_ch_lo;
                        hi_d    = i_ch_hi;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StScan: begin
                // Abort takes priority over a coinciding final handshake.
                if (i_abort) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end else if (valid_q && i_ready) begin
                    if (ch_q < hi_q) begin
                        data_d = pick(i_data, ch_next);
                        ch_d   = ch_next;
                    end else begin
                        valid_d = 1'b0;
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    assign o_data  = data_q;
    assign o_ch    = ch_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_puf_soc_scan_mux.sv
module tb_puf_soc_scan_mux;

    localparam int N_BIT = 4;
    localparam int N_CH  = 12;
    localparam int SEL_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH*N_BIT-1:0] idata = '0;
    logic                  mode = 1'b0;
    logic [SEL_W-1:0]      sel_mux = '0;
    logic                  start = 1'b0;
    logic [SEL_W-1:0]      ch_lo = '0;
    logic [SEL_W-1:0]      ch_hi = '0;
    logic                  abort = 1'b0;
    logic                  ready = 1'b0;
    logic [N_BIT-1:0]      o_data;
    logic [SEL_W-1:0]      o_ch;
    logic                  o_valid, o_busy, o_done, o_err;

    puf_soc_scan_mux #(.N_BIT(N_BIT), .N_CH(N_CH)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_data   (idata),
        .i_mode   (mode),
        .i_sel_mux(sel_mux),
        .i_start  (start),
        .i_ch_lo  (ch_lo),
        .i_ch_hi  (ch_hi),
        .i_abort  (abort),
        .i_ready  (ready),
        .o_data   (o_data),
        .o_ch     (o_ch),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output state after a given clock edge (due = edge count).
    typedef struct {
        int         due;
        logic [3:0] ch;
        logic [3:0] data;
        bit         valid, busy, done, err;
    } exp_t;
    typedef struct {
        logic [3:0] ch;
        logic [3:0] data;
    } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    exp_t  e_m;
    beat_t b_m;

    int n_cmp = 0;
    int n_bad = 0;

    // Last value the model expects on o_ch/o_data.
    logic [3:0] m_ch = '0;
    logic [3:0] m_data = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [3:0] chan(logic [N_CH*N_BIT-1:0] d, int k);
        if (k < N_CH) return d[k*N_BIT +: N_BIT];
        return 4'h0;
    endfunction

    function automatic logic [N_CH*N_BIT-1:0] rand48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[N_CH*N_BIT-1:0];
    endfunction

    task automatic push(int due, logic [3:0] ch, logic [3:0] data, bit v, bit b, bit d, bit e);
        exp_t x;
        x.due = due; x.ch = ch; x.data = data;
        x.valid = v; x.busy = b; x.done = d; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic push_beat(logic [3:0] ch, logic [3:0] data);
        beat_t b;
        b.ch = ch; b.data = data;
        beat_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: inputs and outputs are both stable at the falling edge.
    always @(negedge clk) begin
        if (o_valid && ready && !abort && !rst) begin
            if (beat_q.size() == 0) begin
                check("unexpected_beat", 32'(o_ch), 32'hFFFF);
            end else begin
                b_m = beat_q.pop_front();
                check("beat_ch", 32'(o_ch), 32'(b_m.ch));
                check("beat_data", 32'(o_data), 32'(b_m.data));
            end
        end
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e_m = exp_q.pop_front();
            if (e_m.due < cyc) begin
                check("missed_expectation", 32'(e_m.due), 32'(cyc));
            end else begin
                check("o_ch", 32'(o_ch), 32'(e_m.ch));
                check("o_data", 32'(o_data), 32'(e_m.data));
                check("o_valid", 32'(o_valid), 32'(e_m.valid));
                check("o_busy", 32'(o_busy), 32'(e_m.busy));
                check("o_done", 32'(o_done), 32'(e_m.done));
                check("o_err", 32'(o_err), 32'(e_m.err));
            end
        end
    end

    task automatic manual_cycle(logic [3:0] sel, logic [N_CH*N_BIT-1:0] d);
        rst = 1'b0; mode = 1'b0; start = 1'b0; abort = 1'b0;
        ready = 1'($urandom_range(0, 1));
        sel_mux = sel; idata = d;
        m_ch = sel;
        m_data = chan(d, int'(sel));
        push(cyc + 1, m_ch, m_data, 0, 0, 0, 0);
        tick();
    endtask

    task automatic reject(logic [3:0] lo, logic [3:0] hi);
        mode = 1'b1; start = 1'b1; abort = 1'b0;
        ch_lo = lo; ch_hi = hi; idata = rand48(); sel_mux = 4'($urandom);
        push(cyc + 1, m_ch, m_data, 0, 0, 0, 1);
        tick();
        start = 1'b0;
        push(cyc + 1, m_ch, m_data, 0, 0, 0, 0);
        tick();
    endtask

    task automatic scan(int lo, int hi, int stall_pct, int stall_ch, int abort_ch, int rst_ch);
        int                    cur;
        int                    stalls;
        bit                    fin;
        logic [N_CH*N_BIT-1:0] d;
        cur = lo; stalls = 4; fin = 0;
        d = rand48(); idata = d;
        mode = 1'b1; start = 1'b1; abort = 1'b0; ready = 1'b0;
        ch_lo = 4'(lo); ch_hi = 4'(hi);
        m_ch = 4'(cur); m_data = chan(d, cur);
        push_beat(m_ch, m_data);
        push(cyc + 1, m_ch, m_data, 1, 1, 0, 0);
        tick();
        for (int g = 0; g < 400 && !fin; g++) begin
            // Inputs that must be ignored while busy are scrambled every cycle.
            start = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1));
            sel_mux = 4'($urandom); ch_lo = 4'($urandom); ch_hi = 4'($urandom);
            d = rand48(); idata = d;
            if (cur == rst_ch) begin
                rst = 1'b1;
                exp_q.delete(exp_q.size() - 1);
                beat_q.delete();
                m_ch = '0; m_data = '0;
                push(cyc, 0, 0, 0, 0, 0, 0);
                tick();
                push(cyc, 0, 0, 0, 0, 0, 0);
                rst = 1'b0; start = 1'b0; mode = 1'b1;
                push(cyc + 1, 0, 0, 0, 0, 0, 0);
                tick();
                fin = 1;
            end else if (cur == abort_ch) begin
                // Ready is held high so an abort on the final beat must still win.
                abort = 1'b1; ready = 1'b1;
                beat_q.delete();
                push(cyc + 1, m_ch, m_data, 0, 0, 0, 0);
                tick();
                abort = 1'b0; start = 1'b0; mode = 1'b1;
                push(cyc + 1, m_ch, m_data, 0, 0, 0, 0);
                tick();
                fin = 1;
            end else begin
                if (cur == stall_ch && stalls > 0) begin
                    ready = 1'b0;
                    stalls--;
                end else begin
                    ready = ($urandom_range(0, 99) >= stall_pct);
                end
                if (ready && cur < hi) begin
                    cur++;
                    m_ch = 4'(cur); m_data = chan(d, cur);
                    push_beat(m_ch, m_data);
                    push(cyc + 1, m_ch, m_data, 1, 1, 0, 0);
                    tick();
                end else if (ready) begin
                    push(cyc + 1, m_ch, m_data, 0, 1, 1, 0);
                    tick();
                    start = 1'($urandom_range(0, 1));
                    push(cyc + 1, m_ch, m_data, 0, 0, 0, 0);
                    tick();
                    start = 1'b0; mode = 1'b1;
                    fin = 1;
                end else begin
                    push(cyc + 1, m_ch, m_data, 1, 1, 0, 0);
                    tick();
                end
            end
        end
        if (!fin) check("scan_budget", 32'd0, 32'd1);
    endtask

    initial begin
        logic [N_CH*N_BIT-1:0] d;
        int lo, hi;
        tick();
        tick();
        push(cyc, 0, 0, 0, 0, 0, 0);
        // Manual select with channel 5 = 4'hA.
        d = rand48();
        d[23:20] = 4'hA;
        manual_cycle(4'd5, d);
        manual_cycle(4'd13, rand48());
        for (int i = 0; i < 24; i++) manual_cycle(4'($urandom_range(0, 15)), rand48());
        reject(4'd9, 4'd3);
        reject(4'd2, 4'd12);
        reject(4'd0, 4'd15);
        manual_cycle(4'd7, rand48());
        scan(0, 11, 0, -1, -1, -1);
        scan(3, 6, 0, 4, -1, -1);
        scan(5, 5, 0, -1, -1, -1);
        for (int i = 0; i < 12; i++) begin
            lo = $urandom_range(0, N_CH - 1);
            hi = $urandom_range(lo, N_CH - 1);
            scan(lo, hi, 30, -1, -1, -1);
            manual_cycle(4'($urandom_range(0, 15)), rand48());
        end
        scan(0, 11, 0, -1, 7, -1);
        scan(2, 4, 0, -1, 4, -1);
        manual_cycle(4'd3, rand48());
        scan(0, 11, 20, -1, -1, 7);
        manual_cycle(4'd9, rand48());
        reject(4'd1, 4'd0);
        tick();
        tick();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("beat_queue_drained", 32'(beat_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
